prio_req_arbiter: RTL and testbench

- Four-requester arbiter for one shared resource.
- Selection uses the same fixed-priority casez decode as the selector datapath: bit 3 highest, bit 0 lowest.
- Adds registered grant, hold-while-requesting ownership, a hold-time limit with forced release, and a one-shot mask so a timed-out owner cannot starve others.
- Sits between requester agents and the shared datapath's select input; gnt_id drives that select.

---
 rtl/arb_pkg.sv | 21 ++
 rtl/prio_req_arbiter_if.sv | 28 ++
 rtl/prio_req_arbiter_enc.sv | 23 ++
 rtl/prio_req_arbiter.sv | 97 +++++++++
 tb/tb_prio_req_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the four-requester
// priority arbiter.
package arb_pkg;

  localparam int NREQ             = 4;
  localparam int ID_W             = 2;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_req_arbiter_if.sv
// Request/grant bundle between requester agents (master) and the
// arbiter (slave).
interface prio_req_arbiter_if;
  import arb_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld;
  logic            timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_vld,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_vld,
    output timeout
  );

endinterface

// File: rtl/prio_req_arbiter_enc.sv
// Fixed-priority encoder, bit 3 highest; same casez decode as the
// shared datapath's select logic.
module prio_enc4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] vec,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    idx   = 2'd0;
    valid = 1'b1;
    casez (vec)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      4'b0001: idx = 2'd0;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/prio_req_arbiter.sv
// Four-requester arbiter: registered one-hot grant, ownership held while
// requesting, bounded hold time with forced release and a one-shot mask.
module prio_req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  prio_req_arbiter_if.slave   bus
);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            to_q, to_d;

  logic [NREQ-1:0] eff;
  logic [ID_W-1:0] eff_idx, req_idx, win_idx;
  logic            eff_vld, req_vld;

  assign eff = bus.req & ~mask_q;

  prio_enc4 u_enc_eff (.vec(eff),     .idx(eff_idx), .valid(eff_vld));
  prio_enc4 u_enc_req (.vec(bus.req), .idx(req_idx), .valid(req_vld));

  // Falling back to the raw request keeps the mask from blocking a lone requester.
  assign win_idx = eff_vld ? eff_idx : req_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The mask only ever covers one arbitration, used or not.
        mask_d = '0;
        if (req_vld) begin
          gnt_d   = onehot(win_idx);
          id_d    = win_idx;
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!bus.req[id_q]) begin
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
          gnt_d   = '0;
          cnt_d   = '0;
          to_d    = 1'b1;
          mask_d  = onehot(id_q);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_prio_req_arbiter.sv
// Directed-vector bench for prio_req_arbiter with MAX_HOLD = 8.
module tb_prio_req_arbiter;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  prio_req_arbiter_if bus ();

  prio_req_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle 1 ns past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] g_exp, input logic t_exp);
    vectors++;
    if (bus.gnt !== g_exp || bus.timeout !== t_exp || bus.gnt_vld !== (|g_exp)) begin
      miscompares++;
      $display("[TB] FAIL %s: gnt=%b timeout=%b gnt_vld=%b, expected gnt=%b timeout=%b gnt_vld=%b",
               name, bus.gnt, bus.timeout, bus.gnt_vld, g_exp, t_exp, |g_exp);
    end
  endtask

  task automatic chk_id(input string name, input logic [1:0] id_exp);
    vectors++;
    if (bus.gnt_id !== id_exp) begin
      miscompares++;
      $display("[TB] FAIL %s: gnt_id=%0d expected %0d", name, bus.gnt_id, id_exp);
    end
  endtask

  task automatic settle_idle();
    bus.req = 4'b0000;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    step();
    step();
    chk("reset_hold", 4'b0000, 1'b0);
    rst_n = 1'b1;
    step();
    chk("reset_first_grant", 4'b1000, 1'b0);
    chk_id("reset_first_id", 2'd3);
    settle_idle();
  endtask

  task automatic test_priority();
    bus.req = 4'b0011;
    step();
    chk("prio_low_pair", 4'b0010, 1'b0);
    chk_id("prio_low_pair_id", 2'd1);
    bus.req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_preempt", 4'b0010, 1'b0);
    end
    bus.req = 4'b1001;
    step();
    chk("release_gap", 4'b0000, 1'b0);
    step();
    chk("handover_high", 4'b1000, 1'b0);
    chk_id("handover_high_id", 2'd3);
    settle_idle();
  endtask

  task automatic test_timeout();
    bus.req = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("hold_window", 4'b0100, 1'b0);
    end
    step();
    chk("forced_release", 4'b0000, 1'b1);
    step();
    chk("masked_arb", 4'b0001, 1'b0);
    chk_id("masked_arb_id", 2'd0);
    step();
    chk("masked_owner_held", 4'b0001, 1'b0);
    bus.req = 4'b0100;
    step();
    chk("masked_owner_release", 4'b0000, 1'b0);
    step();
    chk("regrant_after_mask", 4'b0100, 1'b0);
    settle_idle();
  endtask

  task automatic test_lone_timeout();
    bus.req = 4'b0010;
    for (int c = 0; c < 18; c++) begin
      step();
      if ((c % 9) == 8) chk("lone_timeout", 4'b0000, 1'b1);
      else              chk("lone_grant",   4'b0010, 1'b0);
    end
    settle_idle();
  endtask

  task automatic test_simul_release();
    bus.req = 4'b0101;
    for (int i = 0; i < 8; i++) step();
    chk("limit_reached_owner", 4'b0100, 1'b0);
    bus.req = 4'b0001;
    step();
    chk("simul_release_no_timeout", 4'b0000, 1'b0);
    bus.req = 4'b0101;
    step();
    chk("unmasked_arb", 4'b0100, 1'b0);
    chk_id("unmasked_arb_id", 2'd2);
    settle_idle();
  endtask

  task automatic test_async_reset();
    bus.req = 4'b1000;
    step();
    chk("pre_async_grant", 4'b1000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear", 4'b0000, 1'b0);
    bus.req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 4'b0000, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req     = 4'b0000;
    test_reset();
    test_priority();
    test_timeout();
    test_lone_timeout();
    test_simul_release();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
